// File: rtl/apb_to_csr_acc_req_pkg.sv
// Shared types and helpers for the APB-to-CSR access request bridge.
package apb_to_csr_acc_req_pkg;

  // Transfer sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_RESP     = 2'd2
  } state_t;

  localparam int unsigned BITS_PER_BYTE = 8;

  // Widen one byte strobe into the eight bit enables it governs.
  function automatic logic [7:0] expand_strb(input logic strb);
    return {8{strb}};
  endfunction

endpackage

// File: rtl/csr_to_ram_bridge_csr_side_if.sv
// CSR-side access bus between a bus slave and the CSR-to-RAM bridge.
interface csr_to_ram_bridge_csr_side_if #(
  parameter int unsigned WORD_BIT_WIDTH      = 32,
  parameter int unsigned BYTE_ADDR_BIT_WIDTH = 8
);

  logic                           acc_req;
  logic                           acc_req_is_wr;
  logic [BYTE_ADDR_BIT_WIDTH-1:0] byte_addr;
  logic [WORD_BIT_WIDTH-1:0]      wr_data;
  logic [WORD_BIT_WIDTH-1:0]      wr_bit_en;
  logic                           rd_ack;
  logic [WORD_BIT_WIDTH-1:0]      rd_data;
  logic                           wr_ack;

  modport mst_port (
    output acc_req, acc_req_is_wr, byte_addr, wr_data, wr_bit_en,
    input  rd_ack, rd_data, wr_ack
  );

  modport slv_port (
    input  acc_req, acc_req_is_wr, byte_addr, wr_data, wr_bit_en,
    output rd_ack, rd_data, wr_ack
  );

endinterface

// File: rtl/apb_to_csr_acc_req_ack_watchdog.sv
// Saturating cycle counter that flags when an acknowledge has taken too long.
module ack_watchdog #(
  parameter int unsigned TERMINAL_COUNT = 16
) (
  input  logic i_clk,
  input  logic i_async_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CNT_W = $clog2(TERMINAL_COUNT + 1);
  localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TERMINAL_COUNT);
  localparam logic [CNT_W-1:0] ONE_VAL = CNT_W'(1);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Next count: clear outside a wait, otherwise count up and stick at terminal.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (i_enable && (cnt_q != TC_VAL)) begin
      cnt_d = cnt_q + ONE_VAL;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = (cnt_q == TC_VAL);

endmodule

// File: rtl/apb_to_csr_acc_req.sv
// APB4 slave issuing one single-cycle CSR access request per transfer and
// stalling PREADY until the matching acknowledge or a watchdog timeout.
module apb_to_csr_acc_req
  import apb_to_csr_acc_req_pkg::*;
#(
  parameter int unsigned WORD_BIT_WIDTH      = 32,
  parameter int unsigned BYTE_ADDR_BIT_WIDTH = 8,
  parameter int unsigned ACK_TIMEOUT_CYCLES  = 16
) (
  input  logic                           i_clk,
  input  logic                           i_async_rst,
  input  logic                           i_psel,
  input  logic                           i_penable,
  input  logic                           i_pwrite,
  input  logic [BYTE_ADDR_BIT_WIDTH-1:0] i_paddr,
  input  logic [WORD_BIT_WIDTH-1:0]      i_pwdata,
  input  logic [WORD_BIT_WIDTH/8-1:0]    i_pstrb,
  output logic                           o_pready,
  output logic [WORD_BIT_WIDTH-1:0]      o_prdata,
  output logic                           o_pslverr,
  csr_to_ram_bridge_csr_side_if.mst_port if_csr_side
);

  localparam int STRB_W = WORD_BIT_WIDTH / BITS_PER_BYTE;

  // Reject configurations the bridge or the watchdog cannot honour.
  if (ACK_TIMEOUT_CYCLES < 3) begin : g_bad_timeout
    $error("ACK_TIMEOUT_CYCLES must be at least 3");
  end
  if ((WORD_BIT_WIDTH < 8) || ((WORD_BIT_WIDTH & (WORD_BIT_WIDTH - 1)) != 0)) begin : g_bad_word
    $error("WORD_BIT_WIDTH must be a power of two and at least 8");
  end
  if (($bits(if_csr_side.wr_data) != WORD_BIT_WIDTH) ||
      ($bits(if_csr_side.byte_addr) != BYTE_ADDR_BIT_WIDTH)) begin : g_bad_if
    $error("csr-side interface widths differ from this block's widths");
  end

  state_t                         state_d, state_q;
  logic                           acc_req_d, acc_req_q;
  logic                           is_wr_d, is_wr_q;
  logic [BYTE_ADDR_BIT_WIDTH-1:0] byte_addr_d, byte_addr_q;
  logic [WORD_BIT_WIDTH-1:0]      wr_data_d, wr_data_q;
  logic [WORD_BIT_WIDTH-1:0]      wr_bit_en_d, wr_bit_en_q;
  logic                           pready_d, pready_q;
  logic                           pslverr_d, pslverr_q;
  logic [WORD_BIT_WIDTH-1:0]      prdata_d, prdata_q;

  logic setup_s;
  logic ack_match_s;
  logic expired_s;

  assign setup_s     = i_psel && !i_penable;
  assign ack_match_s = is_wr_q ? if_csr_side.wr_ack : if_csr_side.rd_ack;

  ack_watchdog #(
    .TERMINAL_COUNT (ACK_TIMEOUT_CYCLES)
  ) u_ack_watchdog (
    .i_clk       (i_clk),
    .i_async_rst (i_async_rst),
    .i_clear     (state_q != ST_WAIT_ACK),
    .i_enable    (state_q == ST_WAIT_ACK),
    .o_expired   (expired_s)
  );

  // Transfer sequencing: capture on setup, wait for ack or timeout, pulse response.
  always_comb begin
    state_d     = state_q;
    acc_req_d   = 1'b0;
    is_wr_d     = is_wr_q;
    byte_addr_d = byte_addr_q;
    wr_data_d   = wr_data_q;
    wr_bit_en_d = wr_bit_en_q;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    prdata_d    = prdata_q;
    case (state_q)
      ST_IDLE: begin
        if (setup_s) begin
          acc_req_d   = 1'b1;
          is_wr_d     = i_pwrite;
          byte_addr_d = i_paddr;
          wr_data_d   = i_pwrite ? i_pwdata : {WORD_BIT_WIDTH{1'b0}};
          for (int k = 0; k < STRB_W; k++) begin
            wr_bit_en_d[8*k +: 8] = i_pwrite ? expand_strb(i_pstrb[k]) : 8'h00;
          end
          state_d = ST_WAIT_ACK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_ACK: begin
        // An acknowledge coinciding with expiry still completes cleanly.
        if (ack_match_s) begin
          pready_d  = 1'b1;
          pslverr_d = 1'b0;
          if (!is_wr_q) begin
            prdata_d = if_csr_side.rd_data;
          end else begin
            prdata_d = prdata_q;
          end
          state_d = ST_RESP;
        end else if (expired_s) begin
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          prdata_d  = {WORD_BIT_WIDTH{1'b0}};
          state_d   = ST_RESP;
        end else begin
          state_d = ST_WAIT_ACK;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      state_q     <= ST_IDLE;
      acc_req_q   <= 1'b0;
      is_wr_q     <= 1'b0;
      byte_addr_q <= {BYTE_ADDR_BIT_WIDTH{1'b0}};
      wr_data_q   <= {WORD_BIT_WIDTH{1'b0}};
      wr_bit_en_q <= {WORD_BIT_WIDTH{1'b0}};
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      prdata_q    <= {WORD_BIT_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      acc_req_q   <= acc_req_d;
      is_wr_q     <= is_wr_d;
      byte_addr_q <= byte_addr_d;
      wr_data_q   <= wr_data_d;
      wr_bit_en_q <= wr_bit_en_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      prdata_q    <= prdata_d;
    end
  end

  assign o_pready                  = pready_q;
  assign o_pslverr                 = pslverr_q;
  assign o_prdata                  = prdata_q;
  assign if_csr_side.acc_req       = acc_req_q;
  assign if_csr_side.acc_req_is_wr = is_wr_q;
  assign if_csr_side.byte_addr     = byte_addr_q;
  assign if_csr_side.wr_data       = wr_data_q;
  assign if_csr_side.wr_bit_en     = wr_bit_en_q;

endmodule

// File: tb/tb_apb_to_csr_acc_req.sv
// Randomized bench for apb_to_csr_acc_req: the bench plays APB master and
// bridge, and predicts each transfer's outcome from its acknowledge timing.
module tb_apb_to_csr_acc_req;

  localparam int W = 32;
  localparam int A = 8;
  localparam int T = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          psel, penable, pwrite;
  logic [A-1:0]  paddr;
  logic [W-1:0]  pwdata;
  logic [W/8-1:0] pstrb;
  logic          pready, pslverr;
  logic [W-1:0]  prdata;

  csr_to_ram_bridge_csr_side_if #(.WORD_BIT_WIDTH(W), .BYTE_ADDR_BIT_WIDTH(A)) csr_if ();

  apb_to_csr_acc_req #(
    .WORD_BIT_WIDTH(W), .BYTE_ADDR_BIT_WIDTH(A), .ACK_TIMEOUT_CYCLES(T)
  ) dut (
    .i_clk(clk), .i_async_rst(rst),
    .i_psel(psel), .i_penable(penable), .i_pwrite(pwrite),
    .i_paddr(paddr), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_pready(pready), .o_prdata(prdata), .o_pslverr(pslverr),
    .if_csr_side(csr_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model_prdata = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] strobe_mask(input logic [3:0] s);
    logic [31:0] m;
    m = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (s[k]) m = m | (32'hFF << (8 * k));
    end
    return m;
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_pready"},  32'(pready), 32'h0);
    check_eq({tag, "_pslverr"}, 32'(pslverr), 32'h0);
    check_eq({tag, "_prdata"},  prdata, 32'h0);
    check_eq({tag, "_acc_req"}, 32'(csr_if.acc_req), 32'h0);
    check_eq({tag, "_is_wr"},   32'(csr_if.acc_req_is_wr), 32'h0);
    check_eq({tag, "_addr"},    32'(csr_if.byte_addr), 32'h0);
    check_eq({tag, "_wr_data"}, csr_if.wr_data, 32'h0);
    check_eq({tag, "_bit_en"},  csr_if.wr_bit_en, 32'h0);
  endtask

  // Idle cycles with random acknowledges that must be ignored.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("idle_pready", 32'(pready), 32'h0);
      check_eq("idle_acc_req", 32'(csr_if.acc_req), 32'h0);
      check_eq("idle_prdata", prdata, model_prdata);
      psel = 1'b0; penable = 1'b0;
      csr_if.wr_ack  = 1'($urandom_range(0, 1));
      csr_if.rd_ack  = 1'($urandom_range(0, 1));
      csr_if.rd_data = $urandom;
    end
  endtask

  // One APB transfer; ack_cyc < 0 or beyond the window means no acknowledge.
  task automatic run_xfer(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int ack_cyc, input int stray_cyc,
                          input logic [31:0] rdata, input bit drop_psel);
    int done;
    bit err;
    logic [31:0] exp_en, exp_wd;
    if (ack_cyc >= 2 && ack_cyc <= T + 1) begin
      done = ack_cyc + 1; err = 1'b0;
    end else begin
      done = T + 2; err = 1'b1;
    end
    exp_en = wr ? strobe_mask(strb) : 32'h0;
    exp_wd = wr ? wdata : 32'h0;
    for (int c = 0; c <= done; c++) begin
      @(negedge clk);
      if (c > 0) begin
        check_eq("acc_req", 32'(csr_if.acc_req), 32'(c == 1));
        check_eq("pready", 32'(pready), 32'(c == done));
        check_eq("wr_bit_en", csr_if.wr_bit_en, exp_en);
        if (c == 1) begin
          check_eq("is_wr", 32'(csr_if.acc_req_is_wr), 32'(wr));
          check_eq("byte_addr", 32'(csr_if.byte_addr), 32'(addr));
          check_eq("wr_data", csr_if.wr_data, exp_wd);
        end
        if (c == done) begin
          if (err) model_prdata = 32'h0;
          else if (!wr) model_prdata = rdata;
          check_eq("pslverr", 32'(pslverr), 32'(err));
          check_eq("prdata", prdata, model_prdata);
        end else begin
          check_eq("pslverr_low", 32'(pslverr), 32'h0);
        end
      end
      psel    = !(drop_psel && c >= 2 && c < done);
      penable = (c > 0) && psel;
      pwrite  = wr;
      paddr   = (c == 0) ? addr : 8'($urandom);
      pwdata  = (c == 0) ? wdata : $urandom;
      pstrb   = (c == 0) ? strb : 4'($urandom);
      if (c == done) begin
        csr_if.wr_ack = 1'($urandom_range(0, 1));
        csr_if.rd_ack = 1'($urandom_range(0, 1));
      end else begin
        csr_if.wr_ack = (wr && c == ack_cyc) || (!wr && c == stray_cyc);
        csr_if.rd_ack = (!wr && c == ack_cyc) || (wr && c == stray_cyc);
      end
      csr_if.rd_data = (c == ack_cyc) ? rdata : $urandom;
    end
  endtask

  task automatic reset_mid_xfer();
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h44;
    pwdata = 32'h1234_5678; pstrb = 4'hF;
    csr_if.wr_ack = 1'b0; csr_if.rd_ack = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    check_eq("rst_pre_acc_req", 32'(csr_if.acc_req), 32'h0);
    #2 rst = 1'b1;
    psel = 1'b0; penable = 1'b0;
    #1 check_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    model_prdata = 32'h0;
    csr_if.wr_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      csr_if.wr_ack = 1'b0;
      check_eq("late_ack_pready", 32'(pready), 32'h0);
      check_eq("late_ack_acc_req", 32'(csr_if.acc_req), 32'h0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int sel, ack, stray;
    rst = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h0; pwdata = 32'h0; pstrb = 4'h0;
    csr_if.wr_ack = 1'b0; csr_if.rd_ack = 1'b0; csr_if.rd_data = 32'h0;
    #12 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(2);

    run_xfer(1'b1, 8'h10, 32'hDEAD_BEEF, 4'b1111, 2, -1, 32'h0, 1'b0);
    run_xfer(1'b0, 8'h10, 32'h0, 4'b0000, 3, -1, 32'hDEAD_BEEF, 1'b0);
    run_xfer(1'b1, 8'h20, 32'hA5A5_5A5A, 4'b0101, 2, 2, 32'h0, 1'b0);
    run_xfer(1'b0, 8'h30, 32'h0, 4'b0000, -1, -1, 32'hFFFF_FFFF, 1'b0);
    run_xfer(1'b1, 8'h34, 32'h0BAD_F00D, 4'b0011, 2, -1, 32'h0, 1'b0);
    reset_mid_xfer();
    run_xfer(1'b1, 8'h48, 32'hCAFE_0001, 4'b1000, 2, -1, 32'h0, 1'b0);
    run_xfer(1'b1, 8'h4C, 32'h7777_8888, 4'b1111, T + 1, -1, 32'h0, 1'b0);
    run_xfer(1'b0, 8'h50, 32'h0, 4'b0000, T + 1, 3, 32'h1357_9BDF, 1'b0);
    run_xfer(1'b1, 8'h54, 32'h1111_2222, 4'b0000, 3, -1, 32'h0, 1'b0);
    idle_cycles(1);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: ack = 2;
        1: ack = 3;
        2: ack = T + 1;
        3: ack = -1;
        default: ack = $urandom_range(2, T + 1);
      endcase
      stray = ($urandom_range(0, 1) == 1) ? $urandom_range(1, T + 1) : -1;
      run_xfer(1'($urandom_range(0, 1)), 8'($urandom), $urandom, 4'($urandom),
               ack, stray, $urandom, 1'($urandom_range(0, 3) == 0));
      idle_cycles($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_to_csr_acc_req.md
# apb_to_csr_acc_req

APB4 slave that converts each APB transfer into a single-cycle external-access request on the CSR-side bus (`acc_req`/`rd_ack`/`wr_ack`) consumed by the CSR-to-RAM bridge. It sits directly upstream of that bridge and lets a bus master reach the RAM-backed CSR window. It holds `pready` low until the matching acknowledge returns. A watchdog terminates the transfer with `pslverr` if no acknowledge arrives in time.

## Interface
Parameters:
- `WORD_BIT_WIDTH`, 32, data width in bits; a power of 2, at least 8.
- `BYTE_ADDR_BIT_WIDTH`, 8, width of the byte address.
- `ACK_TIMEOUT_CYCLES`, 16, number of WAIT_ACK cycles before an error response. Must be at least 3; elaboration error otherwise.

Ports:
- `i_clk`  in  1  clock.
- `i_async_rst`  in  1  reset, asynchronous, active-high.
- `i_psel`, `i_penable`, `i_pwrite`  in  1  APB4 control.
- `i_paddr`  in  BYTE_ADDR_BIT_WIDTH  byte address.
- `i_pwdata`  in  WORD_BIT_WIDTH  write data.
- `i_pstrb`  in  WORD_BIT_WIDTH/8  byte strobes.
- `o_pready`  out  1  transfer complete.
- `o_prdata`  out  WORD_BIT_WIDTH  read data.
- `o_pslverr`  out  1  error response (timeout).
- `if_csr_side`  `csr_to_ram_bridge_csr_side_if.mst_port`:
  - drives `acc_req`, `acc_req_is_wr`, `byte_addr`, `wr_data`, `wr_bit_en`;
  - samples `rd_ack`, `rd_data`, `wr_ack`.
  - Its `WORD_BIT_WIDTH` and `BYTE_ADDR_BIT_WIDTH` must equal this block's; elaboration error otherwise.

## Operation
- **FSM states:** ST_IDLE, ST_WAIT_ACK, ST_RESP.
- **ST_IDLE:**
  - On `i_psel && !i_penable` (setup phase), register the request fields and assert `acc_req` for exactly one cycle. Go to ST_WAIT_ACK.
  - Request fields: `acc_req_is_wr = i_pwrite`; `byte_addr = i_paddr`, passed through unmodified.
  - For writes: `wr_data = i_pwdata`; each `i_pstrb[k]` is replicated to `wr_bit_en[8k+7:8k]`.
  - For reads: `wr_data = 0` and `wr_bit_en = 0`.
- **ST_WAIT_ACK:**
  - `acc_req` is 0. The watchdog counter increments each cycle, starting at 1.
  - Matching acknowledge (`wr_ack` for a write, `rd_ack` for a read): set `o_pready = 1` and `o_pslverr = 0`. For reads, also `o_prdata = rd_data`. Go to ST_RESP.
  - Non-matching acknowledge: ignored.
  - Counter reaches `ACK_TIMEOUT_CYCLES` with no matching acknowledge: set `o_pready = 1`, `o_pslverr = 1`, `o_prdata = 0`. Go to ST_RESP.
  - Acknowledge in the same cycle as the timeout: the acknowledge wins and there is no error.
- **ST_RESP:** `o_pready` is high for this cycle only. Next cycle: `o_pready = 0`, `o_pslverr = 0`, go to ST_IDLE. `o_prdata` holds until the next response.
- **Ignored inputs:**
  - `i_psel` deasserted in ST_WAIT_ACK (master protocol violation): ignored; the transfer completes internally.
  - Acknowledges in ST_IDLE or ST_RESP: ignored.
  - Setup phases in ST_RESP: ignored. APB requires an access phase between transfers.
- **Strobes:** an all-zero `i_pstrb` write is still issued and acknowledged normally.
- **Reset:** asynchronous and effective immediately, including mid-transfer. FSM goes to ST_IDLE and the counter clears. An acknowledge arriving after reset release is ignored.

## Timing
- **Reset values:** every output is 0 (`o_pready`, `o_prdata`, `o_pslverr`, `acc_req`, `acc_req_is_wr`, `byte_addr`, `wr_data`, `wr_bit_en`).
- **Cycle numbering:** the setup phase is cycle 0; `acc_req` is high in cycle 1.
- **Write:** bridge `wr_ack` in cycle 2; `o_pready` in cycle 3. The transfer takes 4 cycles.
- **Read, RAM without output register:** `rd_ack` in cycle 2; `o_pready` in cycle 3.
- **Read, RAM with output register:** `rd_ack` in cycle 3; `o_pready` in cycle 4.
- **Timeout:** `o_pready` is high with `o_pslverr` high in cycle `ACK_TIMEOUT_CYCLES + 2`.
- **Back-to-back:** the earliest next setup phase is the cycle after `o_pready`. There is no bubble beyond the APB minimum.
- **Register boundaries:** all outputs are registered; no combinational path from APB inputs or acknowledges to outputs.
- **Counter width:** `$clog2(ACK_TIMEOUT_CYCLES + 1)` bits. It saturates and never wraps.

## Structure
- **Package `apb_to_csr_acc_req_pkg`:**
  - `typedef enum logic [1:0] state_t {ST_IDLE, ST_WAIT_ACK, ST_RESP}`;
  - `function expand_strb`, which maps a byte strobe to a bit enable.
- **Sub-module `ack_watchdog`:**
  - ports: clear, enable, terminal-count parameter, `o_expired`;
  - instantiated once for the watchdog counter.

## Test plan
- **Write:** write 0xDEADBEEF to address 0x10 with pstrb=4'b1111; bridge acknowledges in cycle 2.
  - Cycle 1: `acc_req=1`, `is_wr=1`, `wr_bit_en=0xFFFFFFFF`.
  - Cycle 3: `o_pready=1`, `o_pslverr=0`.
- **Read:** read address 0x10; `rd_ack` in cycle 3 with `rd_data=0xDEADBEEF`.
  - Cycle 4: `o_pready=1`, `o_prdata=0xDEADBEEF`.
  - `wr_bit_en=0` throughout.
- **Partial strobe and ack direction:** write with pstrb=4'b0101, and pulse a stray `rd_ack` in cycle 2.
  - `wr_bit_en=0x00FF00FF`.
  - The stray `rd_ack` is ignored; completion follows the `wr_ack` in cycle 3.
- **Timeout:** issue a read with no acknowledge, ACK_TIMEOUT_CYCLES=16.
  - Cycle 18: `o_pready=1`, `o_pslverr=1`, `o_prdata=0`.
  - Then issue a normal write; it completes without error.
- **Reset mid-transfer:** assert `i_async_rst` mid-cycle during ST_WAIT_ACK; later deliver `wr_ack`.
  - All outputs are 0 immediately.
  - The late `wr_ack` produces no `o_pready`.
  - The next transfer completes normally.
- **Ack/timeout coincidence:** deliver `wr_ack` in the same cycle the counter reaches its terminal count.
  - `o_pready=1` with `o_pslverr=0`.
